// File: rtl/traffic_pkg.sv
// Shared encodings for the four-phase junction controller: phase codes,
// light codes and the default timer width.
package traffic_pkg;

  localparam int TW_DEF = 4;

  typedef enum logic [1:0] {
    MAIN_G = 2'b00,
    MAIN_Y = 2'b01,
    SIDE_G = 2'b10,
    SIDE_Y = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

endpackage

// File: rtl/phase_timer.sv
// Saturating phase up-counter with synchronous clear; flags when the live
// duration of the current phase has elapsed.
module phase_timer #(
  parameter int TW      = 4,
  parameter int MAX_CNT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [TW-1:0] i_d,
  output logic [TW-1:0] o_cnt,
  output logic          o_expired
);

  localparam logic [TW-1:0] SAT = TW'(MAX_CNT);

  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_len_m1;

  // A zero duration behaves as a one-cycle phase.
  assign w_len_m1  = (i_d == '0) ? '0 : i_d - 1'b1;
  assign o_expired = (r_cnt >= w_len_m1);
  assign o_cnt     = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (r_cnt != SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Four-phase junction controller: phase FSM, side-road request latches and
// registered light decode around a single shared phase timer.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int TW      = TW_DEF,
  parameter int MAX_CNT = (1 << TW) - 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          car2,
  input  logic          car4,
  input  logic [TW-1:0] d1,
  input  logic [TW-1:0] d2,
  input  logic [TW-1:0] d3,
  input  logic [TW-1:0] d4,
  output logic [1:0]    state,
  output logic [1:0]    l13,
  output logic [1:0]    l24,
  output logic          pend2,
  output logic          pend4,
  output logic [TW-1:0] timer,
  output logic          phase_done
);

  phase_t        r_state;
  phase_t        w_next;
  light_t        r_l13, r_l24;
  light_t        w_l13, w_l24;
  logic          r_pend2, r_pend4;
  logic          r_done;
  logic [TW-1:0] w_dur;
  logic [TW-1:0] w_cnt;
  logic          w_expired;
  logic          w_trans;
  logic          w_clr_req;

  always_comb begin
    w_dur = d1;
    case (r_state)
      MAIN_G: w_dur = d1;
      MAIN_Y: w_dur = d2;
      SIDE_G: w_dur = d3;
      SIDE_Y: w_dur = d4;
    endcase
  end

  phase_timer #(
    .TW      (TW),
    .MAX_CNT (MAX_CNT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_en      (enable),
    .i_clr     (w_trans),
    .i_d       (w_dur),
    .o_cnt     (w_cnt),
    .o_expired (w_expired)
  );

  // Main green only yields once a side-road request has been registered.
  always_comb begin
    w_next = r_state;
    if (enable && w_expired) begin
      case (r_state)
        MAIN_G: if (r_pend2 || r_pend4) w_next = MAIN_Y;
        MAIN_Y: w_next = SIDE_G;
        SIDE_G: w_next = SIDE_Y;
        SIDE_Y: w_next = MAIN_G;
      endcase
    end
  end

  assign w_trans   = (w_next != r_state);
  assign w_clr_req = w_trans && (w_next == SIDE_G);

  always_comb begin
    w_l13 = RED;
    w_l24 = RED;
    case (w_next)
      MAIN_G: w_l13 = GREEN;
      MAIN_Y: w_l13 = YELLOW;
      SIDE_G: w_l24 = GREEN;
      SIDE_Y: w_l24 = YELLOW;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MAIN_G;
      r_l13   <= GREEN;
      r_l24   <= RED;
      r_pend2 <= 1'b0;
      r_pend4 <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_trans;
      if (enable) begin
        r_state <= w_next;
        r_l13   <= w_l13;
        r_l24   <= w_l24;
      end
      // Sensors keep latching while frozen; clearing on side-green entry wins.
      r_pend2 <= w_clr_req ? 1'b0 : (r_pend2 | car2);
      r_pend4 <= w_clr_req ? 1'b0 : (r_pend4 | car4);
    end
  end

  assign state      = r_state;
  assign l13        = r_l13;
  assign l24        = r_l24;
  assign pend2      = r_pend2;
  assign pend4      = r_pend4;
  assign timer      = w_cnt;
  assign phase_done = r_done;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: a cycle model feeds a scoreboard
// queue, plus explicit checks at the milestones of each scenario.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       car2 = 1'b0;
  logic       car4 = 1'b0;
  logic [3:0] d1 = 4'd3, d2 = 4'd11, d3 = 4'd10, d4 = 4'd5;
  logic [1:0] state, l13, l24;
  logic       pend2, pend4, phase_done;
  logic [3:0] timer;

  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;

  logic [1:0]  m_state;
  logic [3:0]  m_timer;
  logic        m_p2, m_p4, m_done;
  logic [12:0] sb_q[$];

  always #5 clk = ~clk;

  traffic_phase_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .car2       (car2),
    .car4       (car4),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .d4         (d4),
    .state      (state),
    .l13        (l13),
    .l24        (l24),
    .pend2      (pend2),
    .pend4      (pend4),
    .timer      (timer),
    .phase_done (phase_done)
  );

  function automatic logic [3:0] lights(input logic [1:0] s);
    case (s)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_timer = 4'd0;
    m_p2    = 1'b0;
    m_p4    = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic c2, input logic c4);
    logic [3:0] dk, lm1;
    logic [1:0] nx;
    case (m_state)
      2'd0:    dk = d1;
      2'd1:    dk = d2;
      2'd2:    dk = d3;
      default: dk = d4;
    endcase
    lm1 = (dk == 4'd0) ? 4'd0 : dk - 4'd1;
    nx  = m_state;
    if (en && (m_timer >= lm1)) begin
      case (m_state)
        2'd0:    if (m_p2 | m_p4) nx = 2'd1;
        2'd1:    nx = 2'd2;
        2'd2:    nx = 2'd3;
        default: nx = 2'd0;
      endcase
    end
    m_done = en && (nx != m_state);
    m_p2 = m_p2 | c2;
    m_p4 = m_p4 | c4;
    if (m_done && nx == 2'd2) begin
      m_p2 = 1'b0;
      m_p4 = 1'b0;
    end
    if (en) begin
      m_timer = m_done ? 4'd0 : ((m_timer == 4'd15) ? 4'd15 : m_timer + 4'd1);
      m_state = nx;
    end
  endtask

  task automatic step(input logic en, input logic c2, input logic c4);
    logic [12:0] e, o;
    enable = en;
    car2   = c2;
    car4   = c4;
    model_step(en, c2, c4);
    sb_q.push_back({m_state, lights(m_state), m_p2, m_p4, m_timer, m_done});
    @(posedge clk);
    #1;
    o = {state, l13, l24, pend2, pend4, timer, phase_done};
    e = sb_q.pop_front();
    if (phase_done) done_seen++;
    chk("cycle", 16'(o), 16'(e));
  endtask

  task automatic run(input int n, input logic c2, input logic c4, input logic en = 1'b1);
    for (int i = 0; i < n; i++) step(en, c2, c4);
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #10;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_l13", 16'(l13), 16'd2);
    chk("rst_l24", 16'(l24), 16'd0);
    chk("rst_pend", 16'({pend2, pend4}), 16'd0);
    chk("rst_timer", 16'(timer), 16'd0);
    chk("rst_done", 16'(phase_done), 16'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Idle main green: timer saturates, no phase change.
    done_seen = 0;
    run(100, 1'b0, 1'b0);
    chk("idle_state", 16'(state), 16'd0);
    chk("idle_lights", 16'({l13, l24}), 16'b1000);
    chk("idle_timer", 16'(timer), 16'd15);
    chk("idle_done_cnt", 16'(done_seen), 16'd0);

    // Single car2 pulse: full side cycle.
    done_seen = 0;
    step(1'b1, 1'b1, 1'b0);
    chk("c2_pend_N", 16'(pend2), 16'd1);
    chk("c2_state_N", 16'(state), 16'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("c2_state_N1", 16'(state), 16'd1);
    chk("c2_done_N1", 16'(phase_done), 16'd1);
    run(10, 1'b0, 1'b0);
    chk("c2_state_N11", 16'(state), 16'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("c2_state_N12", 16'(state), 16'd2);
    chk("c2_pend_N12", 16'(pend2), 16'd0);
    chk("c2_l24_N12", 16'(l24), 16'd2);
    run(9, 1'b0, 1'b0);
    chk("c2_state_N21", 16'(state), 16'd2);
    step(1'b1, 1'b0, 1'b0);
    chk("c2_state_N22", 16'(state), 16'd3);
    run(5, 1'b0, 1'b0);
    chk("c2_state_N27", 16'(state), 16'd0);
    chk("c2_l13_N27", 16'(l13), 16'd2);
    chk("c2_done_cnt", 16'(done_seen), 16'd4);

    // Both sensors at once: a single service clears both.
    run(3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("both_pend", 16'({pend2, pend4}), 16'b11);
    run(12, 1'b0, 1'b0);
    chk("both_sideg", 16'(state), 16'd2);
    chk("both_clear", 16'({pend2, pend4}), 16'b00);
    run(9, 1'b0, 1'b0);
    chk("both_sideg_end", 16'(state), 16'd2);
    step(1'b1, 1'b0, 1'b0);
    chk("both_sidey", 16'(state), 16'd3);
    run(5, 1'b0, 1'b0);
    chk("both_maing", 16'(state), 16'd0);

    // car4 held through side phases: clear wins on entry, re-latched after.
    run(3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    run(12, 1'b0, 1'b1);
    chk("hold_sideg", 16'(state), 16'd2);
    chk("hold_clear", 16'(pend4), 16'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("hold_reset", 16'(pend4), 16'd1);
    run(14, 1'b0, 1'b1);
    chk("hold_maing", 16'(state), 16'd0);
    run(2, 1'b0, 1'b0);
    chk("hold_min_green", 16'(state), 16'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("hold_mainy", 16'(state), 16'd1);
    run(11, 1'b0, 1'b0);
    chk("frz_entry", 16'(state), 16'd2);

    // Freeze mid side green with a car2 pulse during the freeze.
    run(4, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0);
    chk("frz_timer", 16'(timer), 16'd4);
    chk("frz_state", 16'(state), 16'd2);
    chk("frz_pend2", 16'(pend2), 16'd1);
    run(5, 1'b0, 1'b0);
    chk("frz_resume", 16'(state), 16'd2);
    step(1'b1, 1'b0, 1'b0);
    chk("frz_sidey", 16'(state), 16'd3);
    run(5, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0);
    chk("frz_mainy", 16'(state), 16'd1);

    // Zero side-green duration yields a one-cycle phase.
    d3 = 4'd0;
    run(11, 1'b0, 1'b0);
    chk("d0_sideg", 16'(state), 16'd2);
    step(1'b1, 1'b0, 1'b0);
    chk("d0_sidey", 16'(state), 16'd3);
    run(5, 1'b0, 1'b0);
    chk("d0_maing", 16'(state), 16'd0);
    d3 = 4'd10;

    // Asynchronous reset in the middle of main yellow.
    run(2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("ar_pre_state", 16'(state), 16'd1);
    run(3, 1'b0, 1'b0);
    chk("ar_pre_pend4", 16'(pend4), 16'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_state", 16'(state), 16'd0);
    chk("ar_lights", 16'({l13, l24}), 16'b1000);
    chk("ar_pend", 16'({pend2, pend4}), 16'd0);
    chk("ar_timer", 16'(timer), 16'd0);
    chk("ar_done", 16'(phase_done), 16'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    run(4, 1'b0, 1'b0);
    chk("ar_restart_timer", 16'(timer), 16'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Self-contained phase controller for the four-phase junction. It owns the phase register, the phase timer and the request latches. It replaces the external glue that currently advances state, re-arms timers and filters car sensors. Inputs are four per-phase durations and the two side-road sensors. Outputs are the registered phase, the light codes for the main (1/3) and side (2/4) approaches, and status.

Parameters:
TW, 4, width of duration inputs and phase timer
MAX_CNT, 15, timer saturation value (2^TW-1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = sequencer runs; 0 = state and timer frozen
car2  input  1  side-road sensor, approach 2, level-sampled each edge
car4  input  1  side-road sensor, approach 4, level-sampled each edge
d1  input  TW  main-green minimum length, cycles
d2  input  TW  main-yellow length, cycles
d3  input  TW  side-green length, cycles
d4  input  TW  side-yellow length, cycles
state  output  2  current phase: 00 MAIN_G, 01 MAIN_Y, 10 SIDE_G, 11 SIDE_Y
l13  output  2  main light: 00 red, 01 yellow, 10 green
l24  output  2  side light, same encoding
pend2  output  1  latched request, approach 2
pend4  output  1  latched request, approach 4
timer  output  TW  cycles elapsed in current phase
phase_done  output  1  one-cycle pulse in the cycle after any phase change

Behaviour:
- Reset (reset=0, async):
  - state=MAIN_G, l13=10, l24=00.
  - pend2=pend4=0, timer=0, phase_done=0.
  - Reset asserted mid-phase aborts the phase immediately.
- Phase length: L = max(dK,1), where dK is the duration of the current phase (d1..d4). dK is read live every cycle, not latched on entry.
- Timer:
  - Cleared to 0 on the edge that enters a phase.
  - Increments on each enabled edge otherwise.
  - Saturates at MAX_CNT.
- Transitions, evaluated on each edge with enable=1:
  - MAIN_G -> MAIN_Y when timer >= L-1 and (pend2|pend4). Otherwise stay; main green is held indefinitely with no request.
  - MAIN_Y -> SIDE_G when timer >= L-1.
  - SIDE_G -> SIDE_Y when timer >= L-1.
  - SIDE_Y -> MAIN_G when timer >= L-1.
- Comparison uses >=. If dK is lowered below the elapsed count mid-phase, the block transitions on the next enabled edge.
- Lights are decoded from the next state and registered:
  - MAIN_G: l13=10, l24=00
  - MAIN_Y: l13=01, l24=00
  - SIDE_G: l13=00, l24=10
  - SIDE_Y: l13=00, l24=01
- Request latches:
  - pendN is set on any edge where carN=1, including when enable=0.
  - Both latches clear on the edge entering SIDE_G.
  - Same-edge set and clear: clear wins.
  - A car seen during SIDE_G, SIDE_Y or MAIN_G sets the latch again for the next cycle.
  - MAIN_G uses the registered pend value, so a sensor pulse at edge N can cause MAIN_Y at edge N+1 at the earliest.
- enable=0:
  - state, timer and lights hold.
  - phase_done=0.
  - Latches keep capturing.
- phase_done is 1 only in the cycle immediately after a transition edge.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package traffic_pkg:
  - phase encodings MAIN_G, MAIN_Y, SIDE_G, SIDE_Y
  - light encodings RED, YELLOW, GREEN
  - TW default
- One sub-module, phase_timer:
  - up-counter with synchronous clear, enable and saturation
  - compare output expired = (cnt >= max(d,1)-1)
  - instantiated once, with d muxed by current phase
- FSM, latches and light decode remain in traffic_phase_sequencer.

Test Plan:
- Reset, then d1=3,d2=11,d3=10,d4=5, enable=1, no cars for 100 cycles -> state=00, l13=10, l24=00, timer saturates at 15, phase_done never pulses.
- One-cycle car2 pulse at edge N (after min green elapsed) -> pend2=1 at N; state=01 at N+1; SIDE_G at N+12; SIDE_Y at N+22; MAIN_G at N+27; pend2 cleared at N+12; phase_done pulses 4 times.
- car2 and car4 high together at the same edge -> one side-green service of 10 cycles; both latches clear on SIDE_G entry.
- car4 held high through SIDE_G entry and SIDE_Y -> pend4 clear on entry edge, re-set next edge; after return to MAIN_G, stays exactly 3 cycles, then MAIN_Y.
- enable=0 for 7 cycles mid-SIDE_G, with car2 pulsed during the freeze -> timer and state hold, pend2 sets; on enable=1, SIDE_G completes its remaining cycles only.
- d3=0 -> SIDE_G lasts 1 cycle.
- Reset asserted asynchronously mid-MAIN_Y with pend4=1 -> outputs return to reset values immediately, without waiting for a clock edge.
